// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory stage: access sizes, MMIO register map
// and STATUS register layout.
package riscv_mem_pkg;

    // funct3 encoding of the load/store access size
    typedef enum logic [2:0] {
        MS_B  = 3'b000,
        MS_H  = 3'b001,
        MS_W  = 3'b010,
        MS_BU = 3'b100,
        MS_HU = 3'b101
    } memsize_e;

    localparam logic [5:0] OFF_TXDATA   = 6'h00;
    localparam logic [5:0] OFF_STATUS   = 6'h04;
    localparam logic [5:0] OFF_CYCLE_LO = 6'h08;
    localparam logic [5:0] OFF_CYCLE_HI = 6'h0C;
    localparam logic [5:0] OFF_TOHOST   = 6'h10;

    localparam int ST_COUNT_W  = 7;
    localparam int ST_EMPTY    = 7;
    localparam int ST_FULL     = 8;
    localparam int ST_OVERFLOW = 9;

endpackage

// File: rtl/riscv_tx_fifo.sv
// Byte-wide circular TX FIFO with power-of-two depth; pointers wrap naturally
// and a separate occupancy count provides full/empty.
module riscv_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [7:0]                    din,
    input  logic                          pop,
    output logic [7:0]                    dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays are deliberately left out of reset; only the
    // pointers and count define validity, and resetting RAM blocks would
    // prevent them from mapping onto memory macros.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/riscv_dmem.sv
// Data-memory stage: byte-lane RAM with extended loads plus an MMIO window
// holding the TX FIFO, a free-running cycle counter and the tohost/halt register.
module riscv_dmem
    import riscv_mem_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [2:0]  memsize,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        misalign,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] tohost
);

    localparam int          IW        = $clog2(MEM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    logic [31:0]   ram [MEM_WORDS];
    logic [IW-1:0] ram_idx;
    logic [31:0]   ram_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   ram_rdata;
    logic [31:0]   mmio_rdata;
    logic [31:0]   status;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;

    logic is_byte, is_half, is_word, is_signed;
    logic ram_hit, mmio_hit, mmio_word, wr_en, ram_we;
    logic push, pop, status_wr, tohost_wr;

    logic          overflow;
    logic [63:0]   cycle_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // NOTE: every signal driven here receives a default first, so no path
    // through the case statements can leave a value held and infer a latch.
    always_comb begin
        is_byte   = 1'b0;
        is_half   = 1'b0;
        is_word   = 1'b0;
        is_signed = 1'b0;
        case (memsize)
            MS_B:    begin is_byte = 1'b1; is_signed = 1'b1; end
            MS_BU:   is_byte = 1'b1;
            MS_H:    begin is_half = 1'b1; is_signed = 1'b1; end
            MS_HU:   is_half = 1'b1;
            default: is_word = 1'b1;
        endcase
    end

    assign misalign  = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign ram_hit   = (addr < RAM_BYTES);
    assign mmio_hit  = (addr[31:6] == MMIO_BASE[31:6]);
    assign mmio_word = mmio_hit & is_word;
    assign wr_en     = memwrite & ~misalign;
    assign ram_we    = wr_en & ram_hit;
    assign ram_idx   = addr[IW+1:2];

    // Store data is replicated across lanes; byte_en picks the lanes written.
    always_comb begin
        byte_en  = 4'b1111;
        wr_lanes = writedata;
        if (is_byte) begin
            byte_en  = 4'b0001 << addr[1:0];
            wr_lanes = {4{writedata[7:0]}};
        end else if (is_half) begin
            byte_en  = addr[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{writedata[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) ram[ram_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    assign ram_word = ram[ram_idx];
    assign byte_sel = ram_word[{addr[1:0], 3'b000} +: 8];
    assign half_sel = addr[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        ram_rdata = ram_word;
        if (is_byte)      ram_rdata = {{24{is_signed & byte_sel[7]}}, byte_sel};
        else if (is_half) ram_rdata = {{16{is_signed & half_sel[15]}}, half_sel};
    end

    always_comb begin
        status                  = '0;
        status[ST_COUNT_W-1:0]  = ST_COUNT_W'(fifo_count);
        status[ST_EMPTY]        = fifo_empty;
        status[ST_FULL]         = fifo_full;
        status[ST_OVERFLOW]     = overflow;
    end

    always_comb begin
        mmio_rdata = '0;
        case (addr[5:0])
            OFF_STATUS:   mmio_rdata = status;
            OFF_CYCLE_LO: mmio_rdata = cycle_cnt[31:0];
            OFF_CYCLE_HI: mmio_rdata = cycle_cnt[63:32];
            OFF_TOHOST:   mmio_rdata = tohost;
            default:      mmio_rdata = '0;
        endcase
    end

    always_comb begin
        readdata = '0;
        if (!misalign) begin
            if (ram_hit)        readdata = ram_rdata;
            else if (mmio_word) readdata = mmio_rdata;
        end
    end

    assign push      = wr_en & mmio_word & (addr[5:0] == OFF_TXDATA);
    assign status_wr = wr_en & mmio_word & (addr[5:0] == OFF_STATUS);
    assign tohost_wr = wr_en & mmio_word & (addr[5:0] == OFF_TOHOST);
    assign tx_valid  = ~fifo_empty;
    assign pop       = tx_valid & tx_ready;

    riscv_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (writedata[7:0]),
        .pop   (pop),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            halt      <= 1'b0;
            tohost    <= '0;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            // A push into a full FIFO only drops the byte when nothing drains.
            if (status_wr)                        overflow <= 1'b0;
            else if (push & fifo_full & ~pop)     overflow <= 1'b1;
            if (tohost_wr)                        tohost   <= writedata;
            if (tohost_wr && (writedata != '0))   halt     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_dmem.sv
// Self-checking bench for riscv_dmem: byte-addressed memory model, queue-based
// FIFO model and plain counters for the MMIO registers.
module tb_riscv_dmem;

    localparam logic [31:0] MMIO  = 32'hFFFF_0000;
    localparam int          DEPTH = 8;
    localparam int          RAMB  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [2:0]  memsize = 3'b010;
    logic [31:0] addr = 32'h4000_0000;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        misalign;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic [31:0] tohost;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mem_m [RAMB];
    logic [7:0]  txq [$];
    bit          ovf_m;
    bit          halt_m;
    logic [31:0] tohost_m;
    logic [63:0] cyc_m;

    riscv_dmem dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .memsize   (memsize),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .misalign  (misalign),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .tohost    (tohost)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit ref_mis(input logic [31:0] a, input logic [2:0] s);
        case (s)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            default:        return a[1:0] != 2'b00;
        endcase
    endfunction

    function automatic bit ref_word(input logic [2:0] s);
        return !(s == 3'b000 || s == 3'b001 || s == 3'b100 || s == 3'b101);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
        int v;
        logic [31:0] off;
        if (ref_mis(a, s)) return 32'h0;
        if (a < RAMB) begin
            case (s)
                3'b000, 3'b100: begin
                    v = mem_m[a];
                    if (s == 3'b000 && v > 127) v = v - 256;
                end
                3'b001, 3'b101: begin
                    v = mem_m[a] + 256 * mem_m[a+1];
                    if (s == 3'b001 && v > 32767) v = v - 65536;
                end
                default: return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
            endcase
            return 32'(v);
        end
        if (a >= MMIO && a < MMIO + 64 && ref_word(s)) begin
            off = a - MMIO;
            case (off)
                32'h04: return 32'(ovf_m) * 512 + 32'(txq.size() == DEPTH) * 256
                               + 32'(txq.size() == 0) * 128 + 32'(txq.size());
                32'h08: return cyc_m[31:0];
                32'h0C: return cyc_m[63:32];
                32'h10: return tohost_m;
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic step();
        bit p_pop, p_push, was_full;
        logic [31:0] off;
        if (!reset) begin
            txq.delete();
            ovf_m = 0; halt_m = 0; tohost_m = '0; cyc_m = '0;
        end else begin
            cyc_m    = cyc_m + 1;
            p_pop    = (txq.size() > 0) && tx_ready;
            was_full = (txq.size() == DEPTH);
            p_push   = 0;
            if (memwrite && !ref_mis(addr, memsize)) begin
                if (addr < RAMB) begin
                    case (memsize)
                        3'b000, 3'b100: mem_m[addr] = writedata[7:0];
                        3'b001, 3'b101: begin
                            mem_m[addr] = writedata[7:0];
                            mem_m[addr+1] = writedata[15:8];
                        end
                        default: for (int i = 0; i < 4; i++) mem_m[addr+i] = writedata[8*i +: 8];
                    endcase
                end else if (addr >= MMIO && addr < MMIO + 64 && ref_word(memsize)) begin
                    off = addr - MMIO;
                    if (off == 0) p_push = 1;
                    if (off == 4) ovf_m = 0;
                    if (off == 16) begin
                        tohost_m = writedata;
                        if (writedata != 0) halt_m = 1;
                    end
                end
            end
            if (p_pop) void'(txq.pop_front());
            if (p_push) begin
                if (was_full && !p_pop) ovf_m = 1;
                else txq.push_back(writedata[7:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memwrite = w; memsize = s; addr = a; writedata = d;
        #1;
    endtask

    task automatic idle();
        drive(0, 3'b010, 32'h4000_0000, 32'h0);
        step();
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset = 1'b0;
        idle();
        idle();
        drive(0, 3'b010, MMIO + 4, 0);
        exp = ref_load(addr, memsize);
        n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL rst_status: got %h expected %h", readdata, exp); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
        n_cmp++; if (halt !== 1'b0) begin n_bad++; $display("FAIL rst_halt: got %b expected 0", halt); end
        n_cmp++; if (tohost !== 32'h0) begin n_bad++; $display("FAIL rst_tohost: got %h expected 0", tohost); end
        step();
        drive(0, 3'b010, MMIO + 8, 0);
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL rst_cycle: got %h expected 0", readdata); end
        step();
        reset = 1'b1;
    endtask

    task automatic init_ram();
        for (int w = 0; w < 64; w++) begin
            drive(1, 3'b010, 32'(w * 4), $urandom);
            step();
        end
    endtask

    task automatic test_ram_directed();
        logic [2:0]  sz [5]  = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101};
        logic [31:0] ad [5]  = '{32'h10, 32'h10, 32'h13, 32'h12, 32'h12};
        logic [31:0] ex [5]  = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_FF80, 32'hFFFF_8000, 32'h0000_8000};
        drive(1, 3'b010, 32'h10, 32'h8000_00F1);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(0, sz[i], ad[i], 0);
            n_cmp++; if (readdata !== ex[i]) begin n_bad++; $display("FAIL ld_ext[%0d]: got %h expected %h", i, readdata, ex[i]); end
            step();
        end
    endtask

    task automatic test_misalign();
        logic [31:0] pre, exp;
        pre = ref_load(32'h20, 3'b010);
        drive(1, 3'b001, 32'h21, 32'h0000_ABCD);
        n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL sh_misalign: got %b expected 1", misalign); end
        n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL sh_mis_rdata: got %h expected 0", readdata); end
        step();
        drive(0, 3'b010, 32'h20, 0);
        n_cmp++; if (readdata !== pre) begin n_bad++; $display("FAIL sh_mis_nowrite: got %h expected %h", readdata, pre); end
        step();
        drive(1, 3'b000, 32'h21, 32'h0000_005A);
        n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL sb_misalign: got %b expected 0", misalign); end
        step();
        drive(0, 3'b010, 32'h20, 0);
        exp = (pre & 32'hFFFF_00FF) | 32'h0000_5A00;
        n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL sb_lane1: got %h expected %h", readdata, exp); end
        step();
    endtask

    task automatic test_ram_random();
        logic [31:0] a, exp;
        logic [2:0]  s;
        bit          w;
        int          sel;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            s   = 3'($urandom_range(0, 7));
            w   = 1'($urandom_range(0, 1));
            if (sel < 7)       a = $urandom_range(0, 255);
            else if (sel == 7) a = 32'h1000 + $urandom_range(0, 32'h0FFF);
            else if (sel == 8) a = 32'h0001_0000 + $urandom_range(0, 32'hFF);
            else begin
                a = MMIO + $urandom_range(0, 63);
                w = 0;
            end
            drive(w, s, a, $urandom);
            n_cmp++; if (misalign !== ref_mis(a, s)) begin n_bad++; $display("FAIL rnd_misalign: a=%h s=%0d got %b expected %b", a, s, misalign, ref_mis(a, s)); end
            if (!w) begin
                exp = ref_load(a, s);
                n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL rnd_load: a=%h s=%0d got %h expected %h", a, s, readdata, exp); end
            end
            step();
        end
        for (int i = 0; i < 64; i++) begin
            drive(0, 3'b010, 32'(i * 4), 0);
            exp = ref_load(addr, memsize);
            n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL rnd_sweep: a=%h got %h expected %h", addr, readdata, exp); end
            step();
        end
    endtask

    task automatic drain(input string tag, output logic [7:0] last);
        last = 8'h00;
        tx_ready = 1'b1;
        for (int k = 0; k < 20 && txq.size() > 0; k++) begin
            drive(0, 3'b010, 32'h4000_0000, 0);
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) begin
                n_bad++; $display("FAIL %s_drain[%0d]: got v=%b d=%h expected v=1 d=%h", tag, k, tx_valid, tx_data, txq[0]);
            end
            last = txq[0];
            step();
        end
        drive(0, 3'b010, 32'h4000_0000, 0);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL %s_empty: got %b expected 0", tag, tx_valid); end
        step();
        tx_ready = 1'b0;
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] exp;
        logic [7:0]  last;
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            drive(1, 3'b010, MMIO, 32'(i));
            step();
        end
        drive(0, 3'b010, MMIO + 4, 0);
        exp = ref_load(addr, memsize);
        n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL ovf_status: got %h expected %h", readdata, exp); end
        step();
        drain("ovf", last);
        n_cmp++; if (last !== 8'd8) begin n_bad++; $display("FAIL ovf_last: got %h expected 08", last); end
    endtask

    task automatic test_fifo_full_pushpop();
        logic [31:0] exp;
        logic [7:0]  last;
        drive(1, 3'b010, MMIO + 4, 0);
        step();
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 3'b010, MMIO, $urandom);
            step();
        end
        drive(1, 3'b010, MMIO, 32'h0000_00AA);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        drive(0, 3'b010, MMIO + 4, 0);
        exp = ref_load(addr, memsize);
        n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL full_pp_status: got %h expected %h", readdata, exp); end
        step();
        drain("full_pp", last);
        n_cmp++; if (last !== 8'hAA) begin n_bad++; $display("FAIL full_pp_last: got %h expected aa", last); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, exp;
        for (int i = 0; i < 300; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) == 0) ? MMIO + 4 : MMIO;
            drive(1'($urandom_range(0, 2) != 0), 3'b010, a, $urandom);
            n_cmp++; if (tx_valid !== (txq.size() > 0)) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, tx_valid, txq.size() > 0); end
            if (txq.size() > 0) begin
                n_cmp++; if (tx_data !== txq[0]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, tx_data, txq[0]); end
            end
            exp = ref_load(a, 3'b010);
            n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, readdata, exp); end
            step();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_tohost();
        logic [31:0] vals [3] = '{32'h0, 32'h1, 32'h0};
        logic [31:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'b010, MMIO + 16, vals[i]);
            step();
            n_cmp++; if (halt !== halt_m || tohost !== tohost_m) begin
                n_bad++; $display("FAIL tohost[%0d]: got halt=%b tohost=%h expected halt=%b tohost=%h", i, halt, tohost, halt_m, tohost_m);
            end
        end
        drive(0, 3'b010, MMIO + 16, 0);
        exp = ref_load(addr, memsize);
        n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL tohost_rd: got %h expected %h", readdata, exp); end
        step();
        drive(1, 3'b000, MMIO + 16, 32'h0000_0077);
        step();
        n_cmp++; if (tohost !== tohost_m) begin n_bad++; $display("FAIL tohost_nonword: got %h expected %h", tohost, tohost_m); end
        for (int i = 0; i < 2; i++) begin
            drive(1, 3'b010, MMIO, 32'(8'hC0 + i));
            step();
        end
        reset = 1'b0;
        idle();
        reset = 1'b1;
        n_cmp++; if (halt !== 1'b0 || tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL tohost_reset: got halt=%b tx_valid=%b expected 0 0", halt, tx_valid);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] exp;
        reset = 1'b0;
        idle();
        idle();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) idle();
        drive(0, 3'b010, MMIO + 8, 0);
        exp = ref_load(addr, memsize);
        n_cmp++; if (readdata !== exp || exp !== 32'd10) begin n_bad++; $display("FAIL cycle_lo: got %h expected %h", readdata, exp); end
        step();
        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        cyc_m = 64'h0000_0000_FFFF_FFFF;
        memwrite = 0; memsize = 3'b010; addr = MMIO + 12;
        step();
        drive(0, 3'b010, MMIO + 12, 0);
        exp = ref_load(addr, memsize);
        n_cmp++; if (readdata !== exp) begin n_bad++; $display("FAIL cycle_hi_wrap: got %h expected %h", readdata, exp); end
        step();
    endtask

    initial begin
        test_reset();
        init_ram();
        test_ram_directed();
        test_misalign();
        test_ram_random();
        test_fifo_overflow();
        test_fifo_full_pushpop();
        test_back_to_back();
        test_tohost();
        test_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
